te_packet_scheduler: RTL and testbench

- Per-cycle decision engine of the trace encoder.
- Consumes the already-pipelined last/this/next-cycle (lc/tc/nc) instruction flags. Maintains the branch map and the resync counter. Decides when a packet is due and which format/subformat it uses.
- Presents one packet request per handshake to the packet builder/encapsulator through a single-entry output register with valid/ready.

---
 rtl/te_pkg.sv | 26 ++
 rtl/te_resync_cnt.sv | 41 ++++
 rtl/te_packet_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_te_packet_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
// Shared types and constants for the trace-encoder packet scheduler.
package te_pkg;

    localparam int unsigned BMAP_LEN = 31;
    localparam int unsigned BCNT_W   = 5;

    typedef enum logic [1:0] {
        F1 = 2'd1,
        F2 = 2'd2,
        F3 = 2'd3
    } te_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2
    } te_subformat_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_RUN,
        ST_FLUSH
    } te_state_e;

endpackage

// File: rtl/te_resync_cnt.sv
// Resync counter: counts qualified instructions up to max_i and flags a pending resync.
module te_resync_cnt #(
    parameter int unsigned RESYNC_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic [RESYNC_W-1:0] max_i,
    output logic                pending_o
);

    logic [RESYNC_W-1:0] cnt_q;
    logic [RESYNC_W-1:0] cnt_inc;
    logic                pend_q;
    logic                armed;

    always_comb begin
        armed   = (max_i != '0);
        cnt_inc = cnt_q;
        if (inc_i && armed && (cnt_q < max_i)) begin
            cnt_inc = cnt_q + RESYNC_W'(1);
        end
        // Visible in the same cycle the count reaches max, so the decision can act on it.
        pending_o = pend_q | (armed && (cnt_inc >= max_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_inc;
            pend_q <= pending_o;
        end
    end

endmodule

// File: rtl/te_packet_scheduler.sv
// Per-cycle packet decision engine with branch map, resync and a single-entry output register.
// Optional TE_PKT_STATS_EN adds saturating sent/drop packet counters.
module te_packet_scheduler #(
    parameter int unsigned BMAP_LEN = te_pkg::BMAP_LEN,
    parameter int unsigned RESYNC_W = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      tc_qualified_i,
    input  logic                      tc_is_branch_i,
    input  logic                      tc_branch_taken_i,
    input  logic                      tc_exception_i,
    input  logic                      tc_privchange_i,
    input  logic                      lc_exception_i,
    input  logic                      lc_updiscon_i,
    input  logic                      nc_qualified_i,
    input  logic                      nc_exception_i,
    input  logic                      nc_privchange_i,
    input  logic [RESYNC_W-1:0]       resync_max_i,
    input  logic                      pkt_ready_i,
    output logic                      pkt_valid_o,
    output logic [1:0]                pkt_format_o,
    output logic [1:0]                pkt_subformat_o,
    output logic [BMAP_LEN-1:0]       pkt_bmap_o,
    output logic [te_pkg::BCNT_W-1:0] pkt_bcnt_o,
`ifdef TE_PKT_STATS_EN
    output logic [15:0]               pkt_sent_cnt_o,
    output logic [15:0]               pkt_drop_cnt_o,
`endif
    output logic                      pkt_lost_o
);

    import te_pkg::*;

    te_state_e           state_q, state_d;
    logic [BMAP_LEN-1:0] bmap_q, bmap_upd, dec_bmap;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_upd, dec_bcnt;
    logic                br_ins;
    logic                resync_pend, resync_inc, resync_clr;
    logic                dec, load, drop, out_free;
    te_format_e          dec_fmt, map_fmt;
    te_subformat_e       dec_sf;

    te_resync_cnt #(.RESYNC_W(RESYNC_W)) u_resync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (resync_inc),
        .clr_i     (resync_clr),
        .max_i     (resync_max_i),
        .pending_o (resync_pend)
    );

    always_comb begin
        br_ins   = ((state_q == ST_WAIT_FIRST) || (state_q == ST_RUN)) && tc_qualified_i
                   && tc_is_branch_i && (bcnt_q < BCNT_W'(BMAP_LEN));
        bmap_upd = bmap_q;
        if (br_ins) begin
            bmap_upd[bcnt_q] = ~tc_branch_taken_i;
        end
        bcnt_upd = bcnt_q + BCNT_W'(br_ins);
        map_fmt  = (bcnt_upd == '0) ? F2 : F1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (enable_i) state_d = ST_WAIT_FIRST;
            ST_WAIT_FIRST: begin
                if (!enable_i)          state_d = ST_IDLE;
                else if (tc_qualified_i) state_d = ST_RUN;
            end
            ST_RUN:        if (!enable_i) state_d = ST_FLUSH;
            ST_FLUSH:      if (out_free)  state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dec      = 1'b0;
        dec_fmt  = F2;
        dec_sf   = SF_START;
        dec_bmap = bmap_upd;
        dec_bcnt = bcnt_upd;
        unique case (state_q)
            ST_WAIT_FIRST: begin
                if (enable_i && tc_qualified_i) begin
                    dec     = 1'b1;
                    dec_fmt = F3;
                end
            end
            ST_RUN: begin
                if (tc_qualified_i) begin
                    dec = 1'b1;
                    if (tc_exception_i) begin
                        dec_fmt = F3;
                        dec_sf  = SF_TRAP;
                    end else if (lc_exception_i || tc_privchange_i
                                 || (resync_pend && (bcnt_upd == '0))) begin
                        dec_fmt = F3;
                    end else if (lc_updiscon_i || nc_exception_i || nc_privchange_i
                                 || !nc_qualified_i) begin
                        dec_fmt = map_fmt;
                    end else if ((bcnt_upd == BCNT_W'(BMAP_LEN)) || resync_pend) begin
                        // A pending resync with branches outstanding drains the map first.
                        dec_fmt = F1;
                    end else begin
                        dec = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                dec     = 1'b1;
                dec_fmt = (bcnt_q == '0) ? F2 : F1;
            end
            default: ;
        endcase
    end

    always_comb begin
        out_free   = !pkt_valid_o || pkt_ready_i;
        load       = dec && out_free;
        drop       = dec && !out_free && (state_q != ST_FLUSH);
        resync_inc = (state_q == ST_RUN) && tc_qualified_i;
        resync_clr = dec && (state_q != ST_FLUSH) && (dec_fmt == F3) && (dec_sf == SF_START);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bmap_q <= '0;
            bcnt_q <= '0;
        end else if (load || drop) begin
            bmap_q <= '0;
            bcnt_q <= '0;
        end else begin
            bmap_q <= bmap_upd;
            bcnt_q <= bcnt_upd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_valid_o     <= 1'b0;
            pkt_format_o    <= '0;
            pkt_subformat_o <= '0;
            pkt_bmap_o      <= '0;
            pkt_bcnt_o      <= '0;
        end else if (load) begin
            pkt_valid_o     <= 1'b1;
            pkt_format_o    <= dec_fmt;
            pkt_subformat_o <= dec_sf;
            pkt_bmap_o      <= dec_bmap;
            pkt_bcnt_o      <= dec_bcnt;
        end else if (pkt_ready_i) begin
            pkt_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                         pkt_lost_o <= 1'b0;
        else if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) pkt_lost_o <= 1'b0;
        else if (drop)                                       pkt_lost_o <= 1'b1;
    end

`ifdef TE_PKT_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_sent_cnt_o <= '0;
            pkt_drop_cnt_o <= '0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_WAIT_FIRST)) begin
            pkt_sent_cnt_o <= '0;
            pkt_drop_cnt_o <= '0;
        end else begin
            if (pkt_valid_o && pkt_ready_i && (pkt_sent_cnt_o != '1))
                pkt_sent_cnt_o <= pkt_sent_cnt_o + 16'd1;
            if (drop && (pkt_drop_cnt_o != '1))
                pkt_drop_cnt_o <= pkt_drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_te_packet_scheduler.sv
// Directed bench for te_packet_scheduler with hand-computed expected packets.
module tb_te_packet_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        tc_qualified_i, tc_is_branch_i, tc_branch_taken_i;
    logic        tc_exception_i, tc_privchange_i;
    logic        lc_exception_i, lc_updiscon_i;
    logic        nc_qualified_i, nc_exception_i, nc_privchange_i;
    logic [15:0] resync_max_i;
    logic        pkt_ready_i;
    logic        pkt_valid_o;
    logic [1:0]  pkt_format_o, pkt_subformat_o;
    logic [30:0] pkt_bmap_o;
    logic [4:0]  pkt_bcnt_o;
    logic        pkt_lost_o;
`ifdef TE_PKT_STATS_EN
    logic [15:0] pkt_sent_cnt_o, pkt_drop_cnt_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    te_packet_scheduler #(.BMAP_LEN(31), .RESYNC_W(16)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .enable_i          (enable_i),
        .tc_qualified_i    (tc_qualified_i),
        .tc_is_branch_i    (tc_is_branch_i),
        .tc_branch_taken_i (tc_branch_taken_i),
        .tc_exception_i    (tc_exception_i),
        .tc_privchange_i   (tc_privchange_i),
        .lc_exception_i    (lc_exception_i),
        .lc_updiscon_i     (lc_updiscon_i),
        .nc_qualified_i    (nc_qualified_i),
        .nc_exception_i    (nc_exception_i),
        .nc_privchange_i   (nc_privchange_i),
        .resync_max_i      (resync_max_i),
        .pkt_ready_i       (pkt_ready_i),
        .pkt_valid_o       (pkt_valid_o),
        .pkt_format_o      (pkt_format_o),
        .pkt_subformat_o   (pkt_subformat_o),
        .pkt_bmap_o        (pkt_bmap_o),
        .pkt_bcnt_o        (pkt_bcnt_o),
`ifdef TE_PKT_STATS_EN
        .pkt_sent_cnt_o    (pkt_sent_cnt_o),
        .pkt_drop_cnt_o    (pkt_drop_cnt_o),
`endif
        .pkt_lost_o        (pkt_lost_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One qualified instruction; single-cycle event flags are dropped afterwards.
    task automatic qual(input logic br, input logic taken);
        tc_qualified_i    = 1'b1;
        tc_is_branch_i    = br;
        tc_branch_taken_i = taken;
        step();
        tc_qualified_i    = 1'b0;
        tc_is_branch_i    = 1'b0;
        tc_branch_taken_i = 1'b0;
        tc_exception_i    = 1'b0;
        tc_privchange_i   = 1'b0;
        lc_exception_i    = 1'b0;
        lc_updiscon_i     = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [1:0] fmt, input logic [1:0] sf,
                             input logic [4:0] bcnt, input logic [30:0] bmap);
        check({tag, "_valid"}, 64'(pkt_valid_o), 64'(1));
        check({tag, "_fmt"},   64'(pkt_format_o), 64'(fmt));
        check({tag, "_sf"},    64'(pkt_subformat_o), 64'(sf));
        check({tag, "_bcnt"},  64'(pkt_bcnt_o), 64'(bcnt));
        check({tag, "_bmap"},  64'(pkt_bmap_o), 64'(bmap));
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0;
        tc_qualified_i = 1'b0; tc_is_branch_i = 1'b0; tc_branch_taken_i = 1'b0;
        tc_exception_i = 1'b0; tc_privchange_i = 1'b0;
        lc_exception_i = 1'b0; lc_updiscon_i = 1'b0;
        nc_qualified_i = 1'b1; nc_exception_i = 1'b0; nc_privchange_i = 1'b0;
        resync_max_i = 16'd0; pkt_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(pkt_valid_o), 64'(0));
        check("rst_fmt",   64'(pkt_format_o), 64'(0));
        check("rst_bcnt",  64'(pkt_bcnt_o), 64'(0));
        check("rst_bmap",  64'(pkt_bmap_o), 64'(0));
        check("rst_lost",  64'(pkt_lost_o), 64'(0));

        // Start-up: F3 SF0 on first qualified instruction.
        rst_ni = 1'b1; enable_i = 1'b1;
        step();
        step();
        check("wait_novalid", 64'(pkt_valid_o), 64'(0));
        qual(1'b0, 1'b0);
        check_pkt("start", 2'd3, 2'd0, 5'd0, 31'd0);
        step();
        check("start_drop", 64'(pkt_valid_o), 64'(0));

        // T,N,N,T,T then uninferable discontinuity.
        qual(1'b1, 1'b1); qual(1'b1, 1'b0); qual(1'b1, 1'b0); qual(1'b1, 1'b1); qual(1'b1, 1'b1);
        check("br5_nopkt", 64'(pkt_valid_o), 64'(0));
        lc_updiscon_i = 1'b1;
        qual(1'b0, 1'b0);
        check_pkt("updiscon", 2'd1, 2'd0, 5'd5, 31'b00110);

        // Full map of not-taken branches.
        for (int i = 0; i < 30; i++) qual(1'b1, 1'b0);
        check("fill30_nopkt", 64'(pkt_valid_o), 64'(0));
        qual(1'b1, 1'b0);
        check_pkt("full", 2'd1, 2'd0, 5'd31, 31'h7FFF_FFFF);
        lc_updiscon_i = 1'b1;
        qual(1'b0, 1'b0);
        check_pkt("after_full", 2'd2, 2'd0, 5'd0, 31'd0);

        // Trap wins over discontinuity.
        qual(1'b1, 1'b0);
        tc_exception_i = 1'b1; lc_updiscon_i = 1'b1;
        qual(1'b0, 1'b0);
        check_pkt("trap", 2'd3, 2'd1, 5'd1, 31'd1);
        step();
        check("trap_single", 64'(pkt_valid_o), 64'(0));

        // Resync every 4 qualified instructions.
        resync_max_i = 16'd4;
        qual(1'b0, 1'b0); qual(1'b0, 1'b0); qual(1'b0, 1'b0);
        check("rs_nopkt", 64'(pkt_valid_o), 64'(0));
        qual(1'b0, 1'b0);
        check_pkt("rs_sf0", 2'd3, 2'd0, 5'd0, 31'd0);
        qual(1'b1, 1'b0); qual(1'b0, 1'b0); qual(1'b0, 1'b0);
        check("rs2_nopkt", 64'(pkt_valid_o), 64'(0));
        qual(1'b0, 1'b0);
        check_pkt("rs2_f1", 2'd1, 2'd0, 5'd1, 31'd1);
        qual(1'b0, 1'b0);
        check_pkt("rs2_sf0", 2'd3, 2'd0, 5'd0, 31'd0);
        resync_max_i = 16'd0;

        // Back-pressure: hold, drop, sticky lost.
        qual(1'b1, 1'b0);
        pkt_ready_i = 1'b0;
        lc_updiscon_i = 1'b1;
        qual(1'b0, 1'b0);
        check_pkt("bp_load", 2'd1, 2'd0, 5'd1, 31'd1);
        check("bp_lost0", 64'(pkt_lost_o), 64'(0));
        tc_exception_i = 1'b1;
        qual(1'b0, 1'b0);
        check_pkt("bp_drop_hold", 2'd1, 2'd0, 5'd1, 31'd1);
        check("bp_lost1", 64'(pkt_lost_o), 64'(1));
        step();
        check_pkt("bp_hold", 2'd1, 2'd0, 5'd1, 31'd1);
        pkt_ready_i = 1'b1;
        step();
        check("bp_accept", 64'(pkt_valid_o), 64'(0));
        check("bp_lost_sticky", 64'(pkt_lost_o), 64'(1));
        lc_updiscon_i = 1'b1;
        qual(1'b0, 1'b0);
        check_pkt("bp_map_cleared", 2'd2, 2'd0, 5'd0, 31'd0);

        // Disable: flush the outstanding taken branch, lost clears on IDLE entry.
        qual(1'b1, 1'b1);
        enable_i = 1'b0;
        step();
        check("fl_novalid", 64'(pkt_valid_o), 64'(0));
        check("fl_lost", 64'(pkt_lost_o), 64'(1));
        step();
        check_pkt("flush", 2'd1, 2'd0, 5'd1, 31'd0);
        check("idle_lost", 64'(pkt_lost_o), 64'(0));
        step();
        check("idle_novalid", 64'(pkt_valid_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
